// File: rtl/serial_demux_pkg.sv
// serial_demux_pkg: shared types and constants for the serial demux receiver.
//   state_t   - receiver FSM states
//   START_BIT - line level that marks the start of a frame
//   max_w()   - wider of two field widths, sizes the shared field counter
package serial_demux_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        PAR
    } state_t;

    localparam logic START_BIT = 1'b0;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_demux_rx_bit_down_counter.sv
// bit_down_counter: loadable down counter that saturates at zero.
//   clk, rst  - clock, asynchronous active-high reset (count cleared)
//   load      - load load_val (has priority over en)
//   en        - decrement by one unless already zero
//   load_val  - value to load
//   zero, one - count==0 / count==1 flags
module bit_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero,
    output logic         one
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && (cnt != '0))
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);
    assign one  = (cnt == W'(1));

endmodule

// File: rtl/serial_demux_rx.sv
// serial_demux_rx: serial frame receiver. Decodes start bit, channel address
// and payload length from ser_in, then steers the payload bits to one of
// 2**CH_BITS lanes with a per-lane valid strobe. Optional even parity check.
//   clk, rst       - clock, asynchronous active-high reset
//   clk_en         - bit strobe; all sampling and state updates gated by it
//   ser_in         - serial input, idle high, fields MSB first
//   ser_out        - ser_in on the selected lane during payload, else 0
//   ser_out_valid  - one-hot payload strobe for the selected lane
//   chan, len      - address / length of the current or last frame
//   idle           - FSM in IDLE
//   frame_done     - one-cycle pulse after the edge that returns to IDLE
//   parity_err     - sticky parity mismatch, cleared on the next start bit
module serial_demux_rx
    import serial_demux_pkg::*;
#(
    parameter int CH_BITS   = 2,
    parameter int LEN_W     = 5,
    parameter int PARITY_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  ser_in,
    output logic [2**CH_BITS-1:0] ser_out,
    output logic [2**CH_BITS-1:0] ser_out_valid,
    output logic [CH_BITS-1:0]    chan,
    output logic [LEN_W-1:0]      len,
    output logic                  idle,
    output logic                  frame_done,
    output logic                  parity_err
);

    localparam int CW = max_w(CH_BITS, LEN_W);

    state_t               state, state_nx;
    logic                 start;
    logic                 acc;
    logic [CH_BITS-1:0]   chan_nx;
    logic [LEN_W-1:0]     len_nx;

    logic                 fld_load, fld_en, fld_zero, fld_one;
    logic [CW-1:0]        fld_load_val;
    logic                 dat_load, dat_en, dat_zero, dat_one;
    logic                 unused_flags;

    assign start   = (state == IDLE) && (ser_in == START_BIT);
    assign chan_nx = (chan << 1) | CH_BITS'(ser_in);
    assign len_nx  = (len << 1) | LEN_W'(ser_in);

    // Field counter: counts address bits, then is reloaded for length bits.
    assign fld_load     = clk_en && (start || ((state == ADDR) && fld_zero));
    assign fld_load_val = (state == IDLE) ? CW'(CH_BITS - 1) : CW'(LEN_W - 1);
    assign fld_en       = clk_en && ((state == ADDR) || (state == LEN));

    // Payload counter: loaded with the assembled length on the last LEN bit.
    assign dat_load = clk_en && (state == LEN) && fld_zero && (len_nx != '0);
    assign dat_en   = clk_en && (state == DATA);

    // Only one flag of each counter drives the FSM.
    assign unused_flags = fld_one ^ dat_zero;

    bit_down_counter #(.W(CW)) u_fld_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (fld_load),
        .en       (fld_en),
        .load_val (fld_load_val),
        .zero     (fld_zero),
        .one      (fld_one)
    );

    bit_down_counter #(.W(LEN_W)) u_dat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (dat_load),
        .en       (dat_en),
        .load_val (len_nx),
        .zero     (dat_zero),
        .one      (dat_one)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        if (clk_en) begin
            case (state)
                IDLE: if (start) state_nx = ADDR;
                ADDR: if (fld_zero) state_nx = LEN;
                LEN: begin
                    if (fld_zero) begin
                        if (len_nx != '0)
                            state_nx = DATA;
                        else
                            state_nx = (PARITY_EN != 0) ? PAR : IDLE;
                    end
                end
                // Exit on the last payload bit, so test count==1 not zero.
                DATA: if (dat_one) state_nx = (PARITY_EN != 0) ? PAR : IDLE;
                PAR:  state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Field shift registers, parity accumulator and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan       <= '0;
            len        <= '0;
            acc        <= 1'b0;
            parity_err <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state != IDLE) && (state_nx == IDLE);
            if (clk_en) begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            chan       <= '0;
                            len        <= '0;
                            acc        <= 1'b0;
                            parity_err <= 1'b0;
                        end
                    end
                    ADDR: chan <= chan_nx;
                    LEN:  len  <= len_nx;
                    DATA: acc  <= acc ^ ser_in;
                    PAR:  if (ser_in != acc) parity_err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Output decode: zero-latency pass-through on the addressed lane
    always_comb begin
        ser_out_valid = '0;
        ser_out       = '0;
        idle          = (state == IDLE);
        if ((state == DATA) && clk_en) begin
            ser_out_valid[chan] = 1'b1;
            ser_out[chan]       = ser_in;
        end
    end

endmodule

// File: tb/tb_serial_demux_rx.sv
// tb_serial_demux_rx: builds frames as bit lists, derives per-cycle expected
// lane outputs and end-of-frame status from the frame contents, and compares.
module tb_serial_demux_rx;

    localparam int CH_BITS   = 2;
    localparam int LEN_W     = 5;
    localparam int PARITY_EN = 1;
    localparam int NUM_CH    = 2**CH_BITS;
    localparam int HDR       = 1 + CH_BITS + LEN_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              clk_en;
    logic              ser_in;
    logic [NUM_CH-1:0] ser_out;
    logic [NUM_CH-1:0] ser_out_valid;
    logic [CH_BITS-1:0] chan;
    logic [LEN_W-1:0]  len;
    logic              idle;
    logic              frame_done;
    logic              parity_err;

    int n_chk = 0;
    int n_err = 0;

    // reference expectations
    logic exp_idle  = 1'b1;
    logic exp_perr  = 1'b0;
    logic pend_done = 1'b0;
    int   exp_chan  = 0;
    int   exp_len   = 0;

    serial_demux_rx #(
        .CH_BITS   (CH_BITS),
        .LEN_W     (LEN_W),
        .PARITY_EN (PARITY_EN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .ser_in        (ser_in),
        .ser_out       (ser_out),
        .ser_out_valid (ser_out_valid),
        .chan          (chan),
        .len           (len),
        .idle          (idle),
        .frame_done    (frame_done),
        .parity_err    (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One bit over p clk cycles; clk_en only on the last of them.
    task automatic send_bit(input logic b, input int p,
                            input logic [NUM_CH-1:0] ev, input logic [NUM_CH-1:0] eo);
        for (int k = 0; k < p; k++) begin
            @(posedge clk); #1;
            clk_en = (k == p - 1);
            ser_in = b;
            @(negedge clk);
            chk("frame_done", frame_done, pend_done);
            if (pend_done) begin
                chk("chan", chan, exp_chan);
                chk("len", len, exp_len);
            end
            pend_done = 1'b0;
            chk("idle", idle, exp_idle);
            chk("parity_err", parity_err, exp_perr);
            chk("valid", ser_out_valid, clk_en ? ev : '0);
            chk("ser_out", ser_out, clk_en ? eo : '0);
        end
    endtask

    task automatic idle_bit();
        send_bit(1'b1, 1, '0, '0);
    endtask

    // per>0: fixed clk_en period; per==0: random 1..3. abort_at>=0 pulses
    // rst while that bit index is on the line.
    task automatic send_frame(input int c, input int l, input logic [31:0] d,
                              input logic flip, input int per, input int abort_at);
        logic q[$];
        logic par;
        logic [NUM_CH-1:0] ev, eo;
        int p;
        par = flip;
        q.push_back(1'b0);
        for (int i = CH_BITS - 1; i >= 0; i--) q.push_back(c[i]);
        for (int i = LEN_W - 1; i >= 0; i--) q.push_back(l[i]);
        for (int i = 0; i < l; i++) begin
            q.push_back(d[i]);
            par = par ^ d[i];
        end
        if (PARITY_EN != 0) q.push_back(par);
        for (int i = 0; i < q.size(); i++) begin
            p = (per > 0) ? per : int'($urandom_range(1, 3));
            ev = '0;
            eo = '0;
            if (i >= HDR && i < HDR + l) begin
                ev[c] = 1'b1;
                eo[c] = q[i];
            end
            if (i == abort_at) begin
                @(posedge clk); #1;
                clk_en = 1'b1;
                ser_in = q[i];
                #1 rst = 1'b1;
                #1;
                chk("rst_idle", idle, 1'b1);
                chk("rst_valid", ser_out_valid, '0);
                chk("rst_ser_out", ser_out, '0);
                chk("rst_done", frame_done, 1'b0);
                chk("rst_chan", chan, '0);
                chk("rst_len", len, '0);
                ser_in = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                exp_idle  = 1'b1;
                exp_perr  = 1'b0;
                pend_done = 1'b0;
                return;
            end
            send_bit(q[i], p, ev, eo);
            if (i == 0) begin
                exp_idle = 1'b0;
                exp_perr = 1'b0;
            end
        end
        exp_idle  = 1'b1;
        pend_done = 1'b1;
        exp_chan  = c;
        exp_len   = l;
        exp_perr  = (PARITY_EN != 0) ? flip : 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        clk_en = 1'b0;
        ser_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_idle", idle, 1'b1);
        chk("reset_chan", chan, '0);
        chk("reset_len", len, '0);
        chk("reset_perr", parity_err, 1'b0);
        chk("reset_done", frame_done, 1'b0);
        chk("reset_valid", ser_out_valid, '0);
        chk("reset_ser_out", ser_out, '0);
        rst = 1'b0;

        // addr 2, len 3, payload 1,0,1, good parity
        send_frame(2, 3, 32'b101, 1'b0, 1, -1);
        idle_bit();
        // same frame, bad parity; error must hold through idle
        send_frame(2, 3, 32'b101, 1'b1, 1, -1);
        idle_bit();
        idle_bit();
        // zero length frame to addr 3
        send_frame(3, 0, 32'h0, 1'b0, 1, -1);
        idle_bit();
        // len 4 with clk_en every 4th clk
        send_frame(1, 4, 32'b1010, 1'b0, 4, -1);
        idle_bit();
        // reset during the 2nd payload bit, then a clean frame
        send_frame(2, 5, 32'b10110, 1'b0, 1, HDR + 1);
        idle_bit();
        send_frame(3, 3, 32'b110, 1'b0, 1, -1);
        // back-to-back frames
        send_frame(0, 2, 32'b01, 1'b0, 1, -1);
        send_frame(1, 1, 32'b1, 1'b0, 1, -1);
        idle_bit();
        // random frames with random bit strobe spacing
        for (int n = 0; n < 12; n++) begin
            send_frame(int'($urandom_range(0, NUM_CH - 1)),
                       int'($urandom_range(0, 2**LEN_W - 1)),
                       $urandom, logic'($urandom_range(0, 1)), 0, -1);
            if ($urandom_range(0, 1) == 1) idle_bit();
        end
        idle_bit();
        idle_bit();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
